// File: rtl/fifo_drain_arbiter_if.sv
// Handshake bundle between N_SRC source FIFOs, the drain arbiter and its consumer.
// The master modport is the arbiter's view; slave is the FIFO/consumer side.
interface fifo_drain_arbiter_if #(
  parameter int N_SRC = 4,
  parameter int WIDTH = 64
);

  logic [N_SRC-1:0]       src_empty;
  logic [N_SRC*WIDTH-1:0] src_dout;
  logic [N_SRC-1:0]       src_rden;
  logic                   out_rden;
  logic                   out_empty;
  logic [WIDTH-1:0]       out_dout;
  logic [2:0]             out_src;
  logic [N_SRC-1:0]       grant;
  logic                   burst_done;
  logic [8:0]             burst_len;

  modport master (
    input  src_empty, src_dout, out_rden,
    output src_rden, out_empty, out_dout, out_src, grant, burst_done, burst_len
  );

  modport slave (
    output src_empty, src_dout, out_rden,
    input  src_rden, out_empty, out_dout, out_src, grant, burst_done, burst_len
  );

endinterface

// File: rtl/fifo_drain_arbiter.sv
// Round-robin burst scheduler draining N_SRC FWFT FIFOs through one registered
// FWFT output stage; each word carries its source index.
module fifo_drain_arbiter #(
  parameter int N_SRC   = 4,
  parameter int WIDTH   = 64,
  parameter int BURST   = 16,
  parameter int TIMEOUT = 4
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  fifo_drain_arbiter_if.master bus
);

  localparam int                IDX_W       = $clog2(N_SRC);
  localparam int                TO_W        = $clog2(TIMEOUT + 1);
  localparam logic [8:0]        BURST_LEN   = 9'(BURST);
  localparam logic [TO_W-1:0]   TIMEOUT_CNT = TO_W'(TIMEOUT);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(N_SRC - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  function automatic logic [N_SRC-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_SRC-1:0] vec;
    vec      = {N_SRC{1'b0}};
    vec[idx] = 1'b1;
    return vec;
  endfunction

  state_t               state_r;
  logic [IDX_W-1:0]     rr_ptr_r;
  logic [IDX_W-1:0]     gidx_r;
  logic [8:0]           cnt_r;
  logic [TO_W-1:0]      idle_cnt_r;
  logic [N_SRC-1:0]     grant_r;
  logic                 burst_done_r;
  logic [8:0]           burst_len_r;
  logic                 out_empty_r;
  logic [WIDTH-1:0]     out_dout_r;
  logic [2:0]           out_src_r;

  logic                 found_s;
  logic [IDX_W-1:0]     pick_s;
  logic [IDX_W-1:0]     scan_idx_s;
  logic                 gsel_empty_s;
  logic [WIDTH-1:0]     gsel_dout_s;
  logic                 load_s;
  logic [8:0]           cnt_next_s;
  logic [TO_W-1:0]      idle_next_s;
  logic                 release_s;

  // Round-robin search starting just after the most recently granted source.
  always_comb begin
    found_s    = 1'b0;
    pick_s     = rr_ptr_r;
    scan_idx_s = rr_ptr_r;
    for (int i = 1; i <= N_SRC; i++) begin
      scan_idx_s = IDX_W'((int'(rr_ptr_r) + i) % N_SRC);
      if (!found_s && !bus.src_empty[scan_idx_s]) begin
        found_s = 1'b1;
        pick_s  = scan_idx_s;
      end else begin
        pick_s  = pick_s;
      end
    end
  end

  // Granted-source view, load decision and release condition for this cycle.
  always_comb begin
    gsel_empty_s = 1'b1;
    gsel_dout_s  = {WIDTH{1'b0}};
    for (int i = 0; i < N_SRC; i++) begin
      if (gidx_r == IDX_W'(i)) begin
        gsel_empty_s = bus.src_empty[i];
        gsel_dout_s  = bus.src_dout[i*WIDTH +: WIDTH];
      end else begin
        gsel_dout_s  = gsel_dout_s;
      end
    end

    load_s = (state_r == ST_BURST) && !gsel_empty_s && (out_empty_r || bus.out_rden);

    if (load_s) begin
      cnt_next_s = cnt_r + 9'd1;
    end else begin
      cnt_next_s = cnt_r;
    end

    // A stalled but non-empty source counts as active, so stalls never time out.
    if (gsel_empty_s) begin
      idle_next_s = idle_cnt_r + TO_W'(1);
    end else begin
      idle_next_s = {TO_W{1'b0}};
    end

    if (state_r == ST_BURST) begin
      release_s = (load_s && (cnt_next_s == BURST_LEN)) || (idle_next_s == TIMEOUT_CNT);
    end else begin
      release_s = 1'b0;
    end
  end

  // Grant FSM: one arbitration cycle in IDLE, then words until count or timeout.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r      <= ST_IDLE;
      rr_ptr_r     <= LAST_IDX;
      gidx_r       <= {IDX_W{1'b0}};
      cnt_r        <= 9'd0;
      idle_cnt_r   <= {TO_W{1'b0}};
      grant_r      <= {N_SRC{1'b0}};
      burst_done_r <= 1'b0;
      burst_len_r  <= 9'd0;
    end else begin
      burst_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            state_r    <= ST_BURST;
            grant_r    <= onehot(pick_s);
            gidx_r     <= pick_s;
            rr_ptr_r   <= pick_s;
            cnt_r      <= 9'd0;
            idle_cnt_r <= {TO_W{1'b0}};
          end else begin
            grant_r    <= {N_SRC{1'b0}};
          end
        end
        ST_BURST: begin
          cnt_r      <= cnt_next_s;
          idle_cnt_r <= idle_next_s;
          if (release_s) begin
            state_r      <= ST_IDLE;
            grant_r      <= {N_SRC{1'b0}};
            burst_done_r <= 1'b1;
            burst_len_r  <= cnt_next_s;
          end else begin
            state_r      <= ST_BURST;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          grant_r <= {N_SRC{1'b0}};
        end
      endcase
    end
  end

  // Output register stage: filled by a load, emptied by a consumer pop.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      out_empty_r <= 1'b1;
      out_dout_r  <= {WIDTH{1'b0}};
      out_src_r   <= 3'd0;
    end else if (load_s) begin
      out_empty_r <= 1'b0;
      out_dout_r  <= gsel_dout_s;
      out_src_r   <= 3'(gidx_r);
    end else if (bus.out_rden) begin
      out_empty_r <= 1'b1;
    end else begin
      out_empty_r <= out_empty_r;
    end
  end

  assign bus.src_rden   = load_s ? onehot(gidx_r) : {N_SRC{1'b0}};
  assign bus.out_empty  = out_empty_r;
  assign bus.out_dout   = out_dout_r;
  assign bus.out_src    = out_src_r;
  assign bus.grant      = grant_r;
  assign bus.burst_done = burst_done_r;
  assign bus.burst_len  = burst_len_r;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Directed bench for fifo_drain_arbiter: queue-backed FWFT sources, a logging
// consumer, and per-scenario tasks comparing logs against hand-derived values.
module tb_fifo_drain_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_drain_arbiter_if #(.N_SRC(4), .WIDTH(64)) bus ();

  fifo_drain_arbiter #(.N_SRC(4), .WIDTH(64), .BURST(16), .TIMEOUT(4)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int viol = 0;

  logic [63:0] q [4][$];
  logic [2:0]  cons_src [$];
  logic [63:0] cons_data [$];
  int          done_len [$];
  int          done_cyc [$];
  int          pop_cyc [$];
  logic [3:0]  grant_log [$];
  logic [3:0]  prev_grant = 4'd0;

  function automatic logic [63:0] mk_word(input int s, input int n);
    return {8'(s), 56'(n)};
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      bus.src_empty[i] = (q[i].size() == 0);
      bus.src_dout[i*64 +: 64] = (q[i].size() > 0) ? q[i][0] : 64'd0;
    end
  endtask

  task automatic clear_logs();
    cons_src.delete(); cons_data.delete(); done_len.delete(); done_cyc.delete();
    pop_cyc.delete(); grant_log.delete();
    prev_grant = 4'd0;
    viol = 0;
  endtask

  // Sample at negedge, advance one edge, then pop the sources the DUT read.
  task automatic tick();
    logic [3:0]  pops;
    logic [63:0] junk;
    @(negedge clk);
    pops = bus.src_rden;
    if (pops != 4'd0 && ((!bus.out_empty && !bus.out_rden) || !$onehot0(pops))) viol++;
    if (!bus.out_empty && bus.out_rden) begin
      cons_src.push_back(bus.out_src);
      cons_data.push_back(bus.out_dout);
    end
    if (bus.burst_done) begin
      done_len.push_back(int'(bus.burst_len));
      done_cyc.push_back(cyc);
    end
    if (bus.grant != 4'd0 && prev_grant == 4'd0) grant_log.push_back(bus.grant);
    prev_grant = bus.grant;
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (pops[i] && q[i].size() > 0) begin
        junk = q[i].pop_front();
        pop_cyc.push_back(cyc);
      end
    end
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) q[i].delete();
    bus.out_rden = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) q[i].delete();
    bus.out_rden = 1'b1;
    drive();
    @(posedge clk);
    #1;
    vectors++;
    if (bus.out_empty !== 1'b1 || bus.out_dout !== 64'd0 || bus.out_src !== 3'd0 ||
        bus.grant !== 4'd0 || bus.burst_done !== 1'b0 || bus.burst_len !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_values: empty=%b dout=%h src=%0d grant=%b done=%b len=%0d required 1/0/0/0/0/0",
               bus.out_empty, bus.out_dout, bus.out_src, bus.grant, bus.burst_done, bus.burst_len);
    end
    rst_n = 1'b1;
    clear_logs();
    for (int c = 0; c < 20; c++) begin
      tick();
      vectors++;
      if (bus.grant !== 4'd0 || bus.src_rden !== 4'd0 || bus.out_empty !== 1'b1) begin
        miscompares++;
        $display("FAIL idle_quiet cycle %0d: grant=%b rden=%b empty=%b required 0000/0000/1",
                 c, bus.grant, bus.src_rden, bus.out_empty);
      end
    end
  endtask

  task automatic test_single_src();
    do_reset();
    for (int k = 0; k < 40; k++) q[0].push_back(mk_word(0, k));
    drive();
    bus.out_rden = 1'b1;
    for (int c = 0; c < 300 && done_len.size() < 3; c++) tick();
    repeat (4) tick();
    vectors++;
    if (done_len.size() !== 3) begin
      miscompares++;
      $display("FAIL single_burst_count: got %0d required 3", done_len.size());
    end
    for (int k = 0; k < done_len.size() && k < 3; k++) begin
      vectors++;
      if (done_len[k] !== ((k < 2) ? 16 : 8)) begin
        miscompares++;
        $display("FAIL single_burst_len[%0d]: got %0d required %0d", k, done_len[k], (k < 2) ? 16 : 8);
      end
    end
    vectors++;
    if (pop_cyc.size() !== 40) begin
      miscompares++;
      $display("FAIL single_pop_count: got %0d required 40", pop_cyc.size());
    end
    if (pop_cyc.size() == 40 && done_cyc.size() == 3) begin
      vectors++;
      if (done_cyc[0] !== pop_cyc[15]) begin
        miscompares++;
        $display("FAIL single_full_release: done edge %0d required %0d", done_cyc[0], pop_cyc[15]);
      end
      vectors++;
      if (pop_cyc[16] - done_cyc[0] !== 2) begin
        miscompares++;
        $display("FAIL single_dead_cycle: gap %0d required 2", pop_cyc[16] - done_cyc[0]);
      end
      vectors++;
      if (done_cyc[2] - pop_cyc[39] !== 4) begin
        miscompares++;
        $display("FAIL single_timeout_delay: got %0d required 4", done_cyc[2] - pop_cyc[39]);
      end
    end
    for (int k = 0; k < cons_data.size(); k++) begin
      vectors++;
      if (cons_data[k] !== mk_word(0, k) || cons_src[k] !== 3'd0) begin
        miscompares++;
        $display("FAIL single_data[%0d]: got %h src %0d required %h src 0", k, cons_data[k], cons_src[k], mk_word(0, k));
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_seq [4];
    int s;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_seq[i] = 0;
      for (int k = 0; k < 32; k++) q[i].push_back(mk_word(i, k));
    end
    drive();
    bus.out_rden = 1'b1;
    for (int c = 0; c < 400 && done_len.size() < 8; c++) tick();
    repeat (4) tick();
    vectors++;
    if (done_len.size() !== 8 || grant_log.size() !== 8) begin
      miscompares++;
      $display("FAIL rr_counts: bursts %0d grants %0d required 8/8", done_len.size(), grant_log.size());
    end
    for (int k = 0; k < done_len.size() && k < grant_log.size(); k++) begin
      vectors++;
      if (done_len[k] !== 16 || grant_log[k] !== 4'(1 << (k % 4))) begin
        miscompares++;
        $display("FAIL rr_burst[%0d]: len %0d grant %b required 16 %b", k, done_len[k], grant_log[k], 4'(1 << (k % 4)));
      end
    end
    for (int k = 0; k < cons_data.size(); k++) begin
      s = int'(cons_src[k]);
      vectors++;
      if (s > 3) begin
        miscompares++;
        $display("FAIL rr_src[%0d]: got %0d required 0..3", k, s);
      end else begin
        if (cons_data[k] !== mk_word(s, exp_seq[s])) begin
          miscompares++;
          $display("FAIL rr_data[%0d]: got %h required %h", k, cons_data[k], mk_word(s, exp_seq[s]));
        end
        exp_seq[s]++;
      end
    end
    vectors++;
    if (cons_data.size() !== 128) begin
      miscompares++;
      $display("FAIL rr_total_words: got %0d required 128", cons_data.size());
    end
  endtask

  task automatic test_backpressure();
    int exp_seq [2];
    int s;
    do_reset();
    exp_seq[0] = 0;
    exp_seq[1] = 0;
    for (int k = 0; k < 20; k++) begin
      q[0].push_back(mk_word(0, k));
      q[1].push_back(mk_word(1, k));
    end
    drive();
    for (int c = 0; c < 3000 && cons_data.size() < 40; c++) begin
      bus.out_rden = ($urandom_range(0, 99) < 30);
      tick();
    end
    bus.out_rden = 1'b1;
    repeat (10) tick();
    vectors++;
    if (viol !== 0) begin
      miscompares++;
      $display("FAIL bp_rden_violation: got %0d required 0", viol);
    end
    vectors++;
    if (cons_data.size() !== 40 || done_len.size() !== 4 || grant_log.size() !== 4) begin
      miscompares++;
      $display("FAIL bp_counts: words %0d bursts %0d grants %0d required 40/4/4",
               cons_data.size(), done_len.size(), grant_log.size());
    end
    for (int k = 0; k < done_len.size() && k < grant_log.size(); k++) begin
      vectors++;
      if (done_len[k] !== ((k < 2) ? 16 : 4) || grant_log[k] !== ((k % 2 == 0) ? 4'b0001 : 4'b0010)) begin
        miscompares++;
        $display("FAIL bp_burst[%0d]: len %0d grant %b required %0d %b", k, done_len[k], grant_log[k],
                 (k < 2) ? 16 : 4, (k % 2 == 0) ? 4'b0001 : 4'b0010);
      end
    end
    for (int k = 0; k < cons_data.size(); k++) begin
      s = int'(cons_src[k]);
      vectors++;
      if (s > 1) begin
        miscompares++;
        $display("FAIL bp_src[%0d]: got %0d required 0..1", k, s);
      end else begin
        if (cons_data[k] !== mk_word(s, exp_seq[s])) begin
          miscompares++;
          $display("FAIL bp_data[%0d]: got %h required %h", k, cons_data[k], mk_word(s, exp_seq[s]));
        end
        exp_seq[s]++;
      end
    end
  endtask

  task automatic test_refill_gap();
    do_reset();
    for (int k = 0; k < 3; k++) q[2].push_back(mk_word(2, k));
    drive();
    bus.out_rden = 1'b1;
    for (int c = 0; c < 50 && pop_cyc.size() < 3; c++) tick();
    repeat (3) tick();
    for (int k = 3; k < 6; k++) q[2].push_back(mk_word(2, k));
    drive();
    vectors++;
    if (bus.grant !== 4'b0100 || bus.burst_done !== 1'b0 || done_len.size() !== 0) begin
      miscompares++;
      $display("FAIL gap3_continues: grant %b done %b bursts %0d required 0100/0/0",
               bus.grant, bus.burst_done, done_len.size());
    end
    for (int c = 0; c < 60 && done_len.size() < 1; c++) tick();
    vectors++;
    if (done_len.size() !== 1 || pop_cyc.size() !== 6) begin
      miscompares++;
      $display("FAIL gap4_release: bursts %0d pops %0d required 1/6", done_len.size(), pop_cyc.size());
    end else begin
      vectors++;
      if (done_len[0] !== 6 || done_cyc[0] - pop_cyc[5] !== 4) begin
        miscompares++;
        $display("FAIL gap4_len_timing: len %0d delay %0d required 6/4", done_len[0], done_cyc[0] - pop_cyc[5]);
      end
    end
    vectors++;
    if (bus.grant !== 4'd0) begin
      miscompares++;
      $display("FAIL gap4_grant_cleared: got %b required 0000", bus.grant);
    end
    for (int k = 0; k < cons_data.size(); k++) begin
      vectors++;
      if (cons_data[k] !== mk_word(2, k) || cons_src[k] !== 3'd2) begin
        miscompares++;
        $display("FAIL gap_data[%0d]: got %h src %0d required %h src 2", k, cons_data[k], cons_src[k], mk_word(2, k));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 20; k++) q[1].push_back(mk_word(1, k));
    drive();
    bus.out_rden = 1'b1;
    repeat (5) tick();
    for (int k = 0; k < 5; k++) begin
      q[0].push_back(mk_word(0, k));
      q[3].push_back(mk_word(3, k));
    end
    drive();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.out_empty !== 1'b1 || bus.grant !== 4'd0 || bus.src_rden !== 4'd0 || bus.burst_done !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_immediate: empty %b grant %b rden %b done %b required 1/0000/0000/0",
               bus.out_empty, bus.grant, bus.src_rden, bus.burst_done);
    end
    vectors++;
    if (q[1].size() !== 16) begin
      miscompares++;
      $display("FAIL midreset_src1_pops: remaining %0d required 16", q[1].size());
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
    for (int c = 0; c < 10 && grant_log.size() < 1; c++) tick();
    vectors++;
    if (grant_log.size() < 1) begin
      miscompares++;
      $display("FAIL midreset_first_grant: no grant within 10 cycles, required 0001");
    end else if (grant_log[0] !== 4'b0001) begin
      miscompares++;
      $display("FAIL midreset_first_grant: got %b required 0001", grant_log[0]);
    end else begin
      vectors = vectors;
    end
  endtask

  initial begin
    bus.out_rden = 1'b0;
    drive();
    test_reset();
    test_single_src();
    test_round_robin();
    test_backpressure();
    test_refill_gap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, vectors %0d miscompares %0d", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
